// File: rtl/sync_ram.sv
// Single-port synchronous RAM with write-through, registered read data and a
// combinational single-bit tap of the registered read word.
module sync_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 32,
   parameter int BSEL_WIDTH = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  write1_read0,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [BSEL_WIDTH-1:0] bit_sel,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_out_by_bit
);

   // Contents must clear in one cycle on reset, so storage is a register array.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]      word_we;
   logic [DATA_WIDTH-1:0] data_out_q;
   logic [DATA_WIDTH-1:0] data_out_d;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word_we
      assign word_we[gi] = write1_read0 && (address == ADDR_WIDTH'(gi));
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (reset) begin
            mem_q[i] <= '0;
         end else if (word_we[i]) begin
            mem_q[i] <= data_in;
         end
      end
   end

   // An unknown write1_read0 falls through to the read branch.
   always_comb begin
      data_out_d = mem_q[address];
      if (write1_read0) begin
         data_out_d = data_in;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         data_out_q <= '0;
      end else begin
         data_out_q <= data_out_d;
      end
   end

   // Indices beyond the word width select nothing and leave the tap at 0.
   always_comb begin
      data_out_by_bit = 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (bit_sel == BSEL_WIDTH'(i)) begin
            data_out_by_bit = data_out_q[i];
         end
      end
   end

   assign data_out = data_out_q;

endmodule

// File: tb/tb_sync_ram.sv
// Directed plus randomized bench for sync_ram, checked against an array model.
module tb_sync_ram;
   localparam int DW = 8;
   localparam int AW = 5;
   localparam int DEPTH = 32;
   localparam int BW = 3;

   logic          clock = 1'b0;
   logic          reset;
   logic          write1_read0;
   logic [AW-1:0] address;
   logic [DW-1:0] data_in;
   logic [BW-1:0] bit_sel;
   logic [DW-1:0] data_out;
   logic          data_out_by_bit;

   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] exp_out;
   logic [DW-1:0] pattern;
   int            total = 0;
   int            bad = 0;

   always #5 clock = ~clock;

   sync_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .BSEL_WIDTH(BW)) dut (
      .clock          (clock),
      .reset          (reset),
      .write1_read0   (write1_read0),
      .address        (address),
      .data_in        (data_in),
      .bit_sel        (bit_sel),
      .data_out       (data_out),
      .data_out_by_bit(data_out_by_bit)
   );

   task automatic check_word(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
      end
   endtask

   // One clock cycle: apply inputs, advance the model, compare after the edge.
   task automatic cycle(input string tag, input logic rst, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      reset        = rst;
      write1_read0 = we;
      address      = a;
      data_in      = d;
      bit_sel      = BW'($urandom_range(0, DW - 1));
      @(posedge clock);
      #1;
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
         exp_out = '0;
      end else if (we === 1'b1) begin
         ref_mem[a] = d;
         exp_out    = d;
      end else begin
         exp_out = ref_mem[a];
      end
      $display("cycle %s rst=%0b we=%0b addr=%0d din=%0h dout=%0h exp=%0h", tag, rst, we, a, d, data_out, exp_out);
      check_word(tag, data_out, exp_out);
      check_bit({tag, "_bit"}, data_out_by_bit, exp_out[bit_sel]);
   endtask

   initial begin
      reset = 1'b1; write1_read0 = 1'b0; address = '0; data_in = '0; bit_sel = '0;

      // Reset then read every word back as zero.
      cycle("reset", 1'b1, 1'b0, '0, '0);
      for (int j = 0; j < DEPTH; j++) cycle("rd_init", 1'b0, 1'b0, AW'(j), DW'($urandom));

      // Fill with j+1, then read back with junk on data_in.
      for (int j = 0; j < DEPTH; j++) cycle("wr_fill", 1'b0, 1'b1, AW'(j), DW'(j + 1));
      for (int j = 0; j < DEPTH; j++) cycle("rd_fill", 1'b0, 1'b0, AW'(j), DW'(j + 4));

      // Single overwrite, immediate readback, neighbours intact.
      cycle("wr_a5", 1'b0, 1'b1, AW'(7), 8'hA5);
      cycle("rd_a5", 1'b0, 1'b0, AW'(7), 8'h00);
      check_word("a5_const", data_out, 8'hA5);
      cycle("rd_nb6", 1'b0, 1'b0, AW'(6), 8'h00);
      check_word("nb6_const", data_out, 8'h07);
      cycle("rd_nb8", 1'b0, 1'b0, AW'(8), 8'h00);
      check_word("nb8_const", data_out, 8'h09);

      // Reset during a write discards it and clears everything.
      cycle("rst_mid_wr", 1'b1, 1'b1, AW'(3), 8'hFF);
      for (int j = 0; j < DEPTH; j++) cycle("rd_after_rst", 1'b0, 1'b0, AW'(j), 8'hFF);

      // Bit tap sweep within one cycle, data_out held at 8'b1000_0001.
      cycle("wr_81", 1'b0, 1'b1, AW'(10), 8'h81);
      pattern = 8'b1000_0001;
      for (int i = 0; i < DW; i++) begin
         bit_sel = BW'(i);
         #1;
         $display("bitsweep sel=%0d bit=%0b exp=%0b", i, data_out_by_bit, pattern[i]);
         check_bit("bit_sweep", data_out_by_bit, pattern[i]);
      end

      // Alternating random writes and reads against the array model.
      for (int k = 0; k < 40; k++) begin
         cycle("rnd_wr", 1'b0, 1'b1, AW'($urandom), DW'($urandom));
         cycle("rnd_rd", 1'b0, 1'b0, AW'($urandom), DW'($urandom));
      end

      // Unknown write1_read0 behaves as a read.
      cycle("x_wr", 1'b0, 1'b1, AW'(20), 8'h3C);
      cycle("x_as_rd", 1'b0, 1'bx, AW'(20), 8'hC3);
      cycle("x_chk", 1'b0, 1'b0, AW'(20), 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
